// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word width, RAM model status and the RAM arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN  = 2'b01,
    ARB_ERR  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request scanning ptr+1, ptr+2, ... modulo NREQ.
module rr_pick #(
  parameter int  NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   pick_o,
  output logic            any_req_o
);

  assign any_req_o = |req_i;

  // Scan from the farthest slot down so the nearest set request is the last one written.
  always_comb begin
    int          idx;
    logic [IW-1:0] idx_l;
    idx    = 0;
    idx_l  = '0;
    pick_o = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = IW'(idx);
      if (req_i[idx_l]) pick_o = idx_l;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single RAM port; a grant is held until its owner drops its request,
// and a watchdog moves to an error state if the RAM stops answering.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int  NREQ    = 4,
  parameter int  TIMEOUT = 64,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NREQ-1:0] req_ren,
  input  logic [NREQ-1:0] req_wen,
  input  word_t           req_addr  [NREQ],
  input  word_t           req_store [NREQ],
  output logic [NREQ-1:0] req_wait,
  output word_t           req_load,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  ramstate_t       ramstate,
  input  word_t           ramload,
  input  logic            err_clr,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_id,
  output logic            arb_err,
  output arb_state_t      dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] req;
  logic [IW-1:0]   pick;
  logic            any_req;

  assign req       = req_ren | req_wen;
  assign dbg_state = state_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i     (req),
    .ptr_i     (rr_q),
    .pick_o    (pick),
    .any_req_o (any_req)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      rr_q    <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake: a requester holds ren/wen (with addr/store) stable; a word moves in
  // every cycle its req_wait is 0, and dropping both enables releases the grant.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    req_wait    = '1;
    req_load    = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    arb_err     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          gnt_d   = pick;
          state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        grant_valid     = 1'b1;
        grant_id        = gnt_q;
        ramaddr         = req_addr[gnt_q];
        req_wait[gnt_q] = (ramstate != ACCESS);
        if (req_wen[gnt_q]) begin
          ramWEN   = 1'b1;
          ramstore = req_store[gnt_q];
        end else begin
          ramREN   = req_ren[gnt_q];
          req_load = req_ren[gnt_q] ? ramload : '0;
        end
        // The counter leaves for ARB_ERR before it can pass TIMEOUT-1, so it never wraps.
        if (ramstate == ERROR) begin
          state_d = ARB_ERR;
          cnt_d   = '0;
        end else if (!req[gnt_q]) begin
          state_d = ARB_IDLE;
          rr_d    = gnt_q;
          cnt_d   = '0;
        end else if (ramstate == ACCESS) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ARB_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_ERR: begin
        arb_err = 1'b1;
        cnt_d   = '0;
        if (err_clr) state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [NREQ-1:0] req_ren, req_wen, req_wait;
  word_t           req_addr [NREQ];
  word_t           req_store[NREQ];
  word_t           req_load, ramaddr, ramstore, ramload;
  logic            ramREN, ramWEN, err_clr, grant_valid, arb_err;
  logic [1:0]      grant_id;
  ramstate_t       ramstate;
  arb_state_t      dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  // model: who owns the port, who was served last, how long the RAM has stalled
  logic [1:0] m_gnt, m_last;
  bit         m_busy, m_err;
  int         m_stall;

  logic            exp_ren, exp_wen, exp_gv, exp_err;
  word_t           exp_addr, exp_store, exp_load;
  logic [NREQ-1:0] exp_wait;
  logic [1:0]      exp_gid;
  logic [1:0]      exp_q[$];

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

  ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .req_ren     (req_ren),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_store   (req_store),
    .req_wait    (req_wait),
    .req_load    (req_load),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramstate    (ramstate),
    .ramload     (ramload),
    .err_clr     (err_clr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .arb_err     (arb_err),
    .dbg_state   (dbg_state)
  );

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_gnt = '0; m_last = 2'(NREQ - 1); m_stall = 0;
  endtask

  task automatic model_eval();
    exp_ren = 0; exp_wen = 0; exp_addr = '0; exp_store = '0; exp_load = '0;
    exp_wait = '1; exp_gv = 0; exp_gid = '0; exp_err = m_err;
    if (m_busy) begin
      exp_gv = 1; exp_gid = m_gnt; exp_addr = req_addr[m_gnt];
      if (req_wen[m_gnt]) begin
        exp_wen = 1; exp_store = req_store[m_gnt];
      end else if (req_ren[m_gnt]) begin
        exp_ren = 1; exp_load = ramload;
      end
      exp_wait[m_gnt] = (ramstate != ACCESS);
    end
  endtask

  task automatic model_advance();
    logic [NREQ-1:0] wants;
    logic [1:0]      c;
    wants = req_ren | req_wen;
    if (m_err) begin
      if (err_clr) m_err = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        c = 2'((int'(m_last) + k) % NREQ);
        if (!m_busy && wants[c]) begin m_busy = 1; m_gnt = c; end
      end
      m_stall = 0;
    end else if (ramstate == ERROR) begin
      m_busy = 0; m_err = 1; m_stall = 0;
    end else if (!wants[m_gnt]) begin
      m_busy = 0; m_last = m_gnt; m_stall = 0;
    end else if (ramstate == ACCESS) begin
      m_stall = 0;
    end else begin
      m_stall++;
      if (m_stall >= TIMEOUT) begin m_busy = 0; m_err = 1; m_stall = 0; end
    end
  endtask

  task automatic to_sample();
    @(negedge CLK);
    model_eval();
  endtask

  task automatic to_edge();
    @(posedge CLK);
    model_advance();
    #1;
  endtask

  task automatic clear_inputs();
    req_ren = '0; req_wen = '0; ramstate = FREE; ramload = '0; err_clr = 0;
    for (int i = 0; i < NREQ; i++) begin req_addr[i] = '0; req_store[i] = '0; end
  endtask

  task automatic apply_reset();
    nRST = 0;
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 0;
    model_reset();
    #3;
    vectors++; if (ramREN !== 1'b0) begin miscompares++; $display("FAIL rst_ren: got %b expected 0", ramREN); end
    vectors++; if (ramWEN !== 1'b0) begin miscompares++; $display("FAIL rst_wen: got %b expected 0", ramWEN); end
    vectors++; if (req_wait !== 4'hF) begin miscompares++; $display("FAIL rst_wait: got %h expected f", req_wait); end
    vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL rst_gv: got %b expected 0", grant_valid); end
    vectors++; if (arb_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", arb_err); end
    vectors++; if (ramaddr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", ramaddr); end
    vectors++; if (req_load !== 32'h0) begin miscompares++; $display("FAIL rst_load: got %h expected 0", req_load); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_gid: got %0d expected 0", grant_id); end
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  task automatic test_fairness();
    logic [1:0] want;
    exp_q = {};
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    req_ren = '1; ramstate = BUSY;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NREQ; i++) req_addr[i] = word_t'($urandom);
      to_sample();
      vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL fair_idle%0d: got gv %b expected 0", k, grant_valid); end
      to_edge();
      ramstate = ACCESS; ramload = word_t'($urandom);
      to_sample();
      want = exp_q.pop_front();
      vectors++;
      if (grant_valid !== 1'b1 || grant_id !== want) begin
        miscompares++; $display("FAIL fair_order%0d: got gv %b id %0d expected id %0d", k, grant_valid, grant_id, want);
      end
      to_edge();
      req_ren[want] = 1'b0; ramstate = BUSY;
      to_sample();
      vectors++; if (ramREN !== 1'b0) begin miscompares++; $display("FAIL fair_rel%0d: got ren %b expected 0", k, ramREN); end
      to_edge();
      req_ren = '1;
    end
    clear_inputs();
  endtask

  task automatic test_single_read();
    req_ren[2] = 1'b1; req_addr[2] = 32'h40; ramstate = BUSY;
    to_sample();
    vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL rd_arb: got gv %b expected 0", grant_valid); end
    to_edge();
    to_sample();
    vectors++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin miscompares++; $display("FAIL rd_gnt: got gv %b id %0d expected 1/2", grant_valid, grant_id); end
    vectors++; if (ramaddr !== 32'h40 || ramREN !== 1'b1) begin miscompares++; $display("FAIL rd_addr: got %h ren %b expected 40/1", ramaddr, ramREN); end
    vectors++; if (req_wait !== 4'hF) begin miscompares++; $display("FAIL rd_wait_busy: got %h expected f", req_wait); end
    to_edge();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    to_sample();
    vectors++; if (req_load !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_load: got %h expected deadbeef", req_load); end
    vectors++; if (req_wait !== 4'b1011) begin miscompares++; $display("FAIL rd_wait_acc: got %b expected 1011", req_wait); end
    to_edge();
    req_ren[2] = 1'b0; ramstate = FREE; ramload = '0;
    to_sample();
    vectors++; if (ramREN !== 1'b0 || req_load !== 32'h0) begin miscompares++; $display("FAIL rd_rel: got ren %b load %h expected 0/0", ramREN, req_load); end
    to_edge();
    to_sample();
    vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL rd_idle: got gv %b expected 0", grant_valid); end
    to_edge();
    clear_inputs();
  endtask

  task automatic test_burst();
    word_t d;
    req_wen[3] = 1'b1; req_addr[3] = 32'h80; req_ren[0] = 1'b1; req_addr[0] = word_t'($urandom);
    ramstate = BUSY;
    to_sample(); to_edge();
    ramstate = ACCESS;
    for (int w = 0; w < 2; w++) begin
      d = word_t'($urandom);
      req_addr[3] = 32'h80 + 32'(4 * w); req_store[3] = d;
      to_sample();
      vectors++; if (grant_id !== 2'd3 || ramWEN !== 1'b1 || ramREN !== 1'b0) begin miscompares++; $display("FAIL burst_own%0d: got id %0d wen %b ren %b expected 3/1/0", w, grant_id, ramWEN, ramREN); end
      vectors++; if (ramaddr !== 32'h80 + 32'(4 * w) || ramstore !== d) begin miscompares++; $display("FAIL burst_data%0d: got %h/%h expected %h/%h", w, ramaddr, ramstore, 32'h80 + 32'(4 * w), d); end
      vectors++; if (req_wait !== 4'b0111) begin miscompares++; $display("FAIL burst_wait%0d: got %b expected 0111", w, req_wait); end
      to_edge();
    end
    req_wen[3] = 1'b0; ramstate = BUSY;
    to_sample();
    vectors++; if (ramWEN !== 1'b0 || grant_id !== 2'd3) begin miscompares++; $display("FAIL burst_rel: got wen %b id %0d expected 0/3", ramWEN, grant_id); end
    to_edge();
    to_sample();
    vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL burst_idle: got gv %b expected 0", grant_valid); end
    to_edge();
    ramstate = ACCESS;
    to_sample();
    vectors++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin miscompares++; $display("FAIL burst_next: got gv %b id %0d expected 1/0", grant_valid, grant_id); end
    to_edge();
    req_ren[0] = 1'b0;
    to_sample(); to_edge();
    clear_inputs();
  endtask

  task automatic test_collision();
    word_t d;
    d = word_t'($urandom);
    req_ren[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = word_t'($urandom); req_store[1] = d;
    ramload = word_t'($urandom) | 32'h1; ramstate = ACCESS;
    to_sample(); to_edge();
    to_sample();
    vectors++; if (grant_id !== 2'd1 || ramWEN !== 1'b1 || ramREN !== 1'b0) begin miscompares++; $display("FAIL col_en: got id %0d wen %b ren %b expected 1/1/0", grant_id, ramWEN, ramREN); end
    vectors++; if (req_load !== 32'h0 || ramstore !== d) begin miscompares++; $display("FAIL col_data: got load %h store %h expected 0/%h", req_load, ramstore, d); end
    to_edge();
    req_ren[1] = 1'b0; req_wen[1] = 1'b0; ramstate = FREE;
    to_sample(); to_edge();
    clear_inputs();
  endtask

  task automatic test_timeout();
    req_ren[2] = 1'b1; ramstate = BUSY;
    to_sample(); to_edge();
    for (int s = 0; s < TIMEOUT; s++) begin
      to_sample();
      vectors++; if (arb_err !== 1'b0 || grant_valid !== 1'b1) begin miscompares++; $display("FAIL to_stall%0d: got err %b gv %b expected 0/1", s, arb_err, grant_valid); end
      to_edge();
    end
    to_sample();
    vectors++; if (arb_err !== 1'b1 || req_wait !== 4'hF) begin miscompares++; $display("FAIL to_err: got err %b wait %h expected 1/f", arb_err, req_wait); end
    vectors++; if (ramREN !== 1'b0 || grant_valid !== 1'b0) begin miscompares++; $display("FAIL to_err_en: got ren %b gv %b expected 0/0", ramREN, grant_valid); end
    to_edge();
    err_clr = 1'b1; req_ren = 4'b1101;
    to_sample();
    vectors++; if (arb_err !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got err %b expected 1", arb_err); end
    to_edge();
    err_clr = 1'b0;
    to_sample();
    vectors++; if (arb_err !== 1'b0 || grant_valid !== 1'b0) begin miscompares++; $display("FAIL to_clr: got err %b gv %b expected 0/0", arb_err, grant_valid); end
    to_edge();
    to_sample();
    vectors++; if (grant_id !== 2'd2 || grant_valid !== 1'b1) begin miscompares++; $display("FAIL to_ptr: got id %0d gv %b expected 2/1", grant_id, grant_valid); end
    to_edge();
    req_ren = '0; ramstate = ERROR;
    to_sample(); to_edge();
    ramstate = FREE; err_clr = 1'b1;
    to_sample();
    vectors++; if (arb_err !== 1'b1) begin miscompares++; $display("FAIL to_errwin: got err %b expected 1", arb_err); end
    to_edge();
    err_clr = 1'b0;
    to_sample(); to_edge();
    clear_inputs();
  endtask

  task automatic test_random();
    int r;
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req_ren[i] = ~req_ren[i];
        if ($urandom_range(0, 11) == 0) req_wen[i] = ~req_wen[i];
        req_addr[i] = word_t'($urandom); req_store[i] = word_t'($urandom);
      end
      r = int'($urandom_range(0, 19));
      if (r == 0) ramstate = ERROR;
      else if (r <= 8) ramstate = ACCESS;
      else if (r <= 16) ramstate = BUSY;
      else ramstate = FREE;
      ramload = word_t'($urandom);
      err_clr = ($urandom_range(0, 3) == 0);
      to_sample();
      vectors++; if (ramREN !== exp_ren) begin miscompares++; $display("FAIL rnd_ren c%0d: got %b expected %b", c, ramREN, exp_ren); end
      vectors++; if (ramWEN !== exp_wen) begin miscompares++; $display("FAIL rnd_wen c%0d: got %b expected %b", c, ramWEN, exp_wen); end
      vectors++; if (ramaddr !== exp_addr) begin miscompares++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, ramaddr, exp_addr); end
      vectors++; if (ramstore !== exp_store) begin miscompares++; $display("FAIL rnd_store c%0d: got %h expected %h", c, ramstore, exp_store); end
      vectors++; if (req_wait !== exp_wait) begin miscompares++; $display("FAIL rnd_wait c%0d: got %b expected %b", c, req_wait, exp_wait); end
      vectors++; if (req_load !== exp_load) begin miscompares++; $display("FAIL rnd_load c%0d: got %h expected %h", c, req_load, exp_load); end
      vectors++; if (grant_valid !== exp_gv) begin miscompares++; $display("FAIL rnd_gv c%0d: got %b expected %b", c, grant_valid, exp_gv); end
      vectors++; if (grant_id !== exp_gid) begin miscompares++; $display("FAIL rnd_gid c%0d: got %0d expected %0d", c, grant_id, exp_gid); end
      vectors++; if (arb_err !== exp_err) begin miscompares++; $display("FAIL rnd_err c%0d: got %b expected %b", c, arb_err, exp_err); end
      to_edge();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    apply_reset();
    req_wen[1] = 1'b1; req_addr[1] = word_t'($urandom); req_store[1] = word_t'($urandom); ramstate = BUSY;
    to_sample(); to_edge();
    to_sample();
    vectors++; if (ramWEN !== 1'b1 || grant_id !== 2'd1) begin miscompares++; $display("FAIL mid_own: got wen %b id %0d expected 1/1", ramWEN, grant_id); end
    #2;
    nRST = 0;
    model_reset();
    #1;
    vectors++; if (ramWEN !== 1'b0) begin miscompares++; $display("FAIL mid_async_wen: got %b expected 0", ramWEN); end
    vectors++; if (req_wait !== 4'hF || grant_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_wait: got %h gv %b expected f/0", req_wait, grant_valid); end
    req_wen = '0; req_ren = '1;
    @(posedge CLK);
    #1;
    nRST = 1;
    to_sample(); to_edge();
    to_sample();
    vectors++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin miscompares++; $display("FAIL mid_prio: got gv %b id %0d expected 1/0", grant_valid, grant_id); end
    to_edge();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_burst();
    test_collision();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
